// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush scheduler for the 5-stage pipelined core. Merges the
// load-use, taken-branch and data-memory-wait hazards into one set of
// pipeline-register enables and bubble/flush controls, runs a memory-wait
// timeout FSM that parks the core in HALT, and keeps saturating stall/flush
// performance counters.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   ifid_instr        instruction held in IF/ID (rs1=[19:15], rs2=[24:20])
//   ifid_use_rs1/rs2  IF/ID instruction actually reads rs1 / rs2
//   idex_memread      ID/EX instruction is a load
//   idex_rd           ID/EX destination register
//   ex_branch_taken   EX resolved a taken branch/jump this cycle
//   mem_req/mem_ready data-memory access handshake from MEM
//   pc_write, ifid_write, exmem_write        register enables
//   ifid_flush, idex_bubble, memwb_bubble    NOP/bubble injection
//   halted            FSM parked in HALT after a memory timeout
//   stall_cycles      saturating count of load-use + memory-freeze cycles
//   flush_count       saturating count of taken-branch flush cycles
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int N           = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TW          = 8,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  ifid_instr,
  input  logic          ifid_use_rs1,
  input  logic          ifid_use_rs2,
  input  logic          idex_memread,
  input  logic [4:0]    idex_rd,
  input  logic          ex_branch_taken,
  input  logic          mem_req,
  input  logic          mem_ready,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          ifid_flush,
  output logic          idex_bubble,
  output logic          exmem_write,
  output logic          memwb_bubble,
  output logic          halted,
  output logic [CW-1:0] stall_cycles,
  output logic [CW-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  logic [1:0]    state_r, state_nxt_s;
  logic [TW-1:0] wait_cnt_r, wait_cnt_nxt_s, wait_inc_s;
  logic [CW-1:0] stall_cycles_r, flush_count_r;
  logic [4:0]    rs1_s, rs2_s;
  logic          memwait_s, loaduse_s, halt_s;
  logic          stall_inc_s, flush_inc_s;
  logic          unused_instr_s;

  assign rs1_s = ifid_instr[19:15];
  assign rs2_s = ifid_instr[24:20];
  // Only the register-specifier fields matter to hazard detection.
  assign unused_instr_s = ^{ifid_instr[N-1:25], ifid_instr[14:0]};

  // Hazard detection terms.
  always_comb begin
    memwait_s = mem_req & ~mem_ready;
    loaduse_s = idex_memread & (idex_rd != 5'd0) &
                ((ifid_use_rs1 & (idex_rd == rs1_s)) |
                 (ifid_use_rs2 & (idex_rd == rs2_s)));
    halt_s    = (state_r == ST_HALT);
  end

  // Pipeline control outputs, resolved in priority HALT > memwait > branch > load-use.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (halt_s) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      halted       = 1'b1;
    end else if (memwait_s) begin
      // Freeze everything upstream of MEM; branch/load-use wait for the release.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Flushing the consumer makes any simultaneous load-use moot.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
    end else if (loaduse_s) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_bubble  = 1'b1;
    end else begin
      pc_write     = 1'b1;
    end
  end

  // Memory-wait timeout FSM: wait_cnt holds the number of consecutive wait
  // cycles already completed, so HALT is entered as the MEM_TIMEOUT-th one ends.
  always_comb begin
    wait_inc_s     = wait_cnt_r + TW'(1);
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        if (memwait_s) begin
          wait_cnt_nxt_s = wait_inc_s;
          if (wait_inc_s == TW'(MEM_TIMEOUT)) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_MEM_WAIT;
          end
        end else begin
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = {TW{1'b0}};
        end
      end
      ST_HALT: begin
        state_nxt_s    = ST_HALT;
        wait_cnt_nxt_s = wait_cnt_r;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = {TW{1'b0}};
      end
    endcase
  end

  // Counter increment qualifiers; both frozen in HALT.
  always_comb begin
    stall_inc_s = ~halt_s & (memwait_s | (~ex_branch_taken & loaduse_s));
    flush_inc_s = ~halt_s & ~memwait_s & ex_branch_taken;
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {TW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r <= {CW{1'b0}};
      flush_count_r  <= {CW{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cycles_r != {CW{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + CW'(1);
      end
      if (flush_inc_s && (flush_count_r != {CW{1'b1}})) begin
        flush_count_r <= flush_count_r + CW'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule
